// File: rtl/ft245_sync_device_emu.sv
// FT245 synchronous FIFO bus, chip-side emulator.
// Presents txen/rxfn/data/ben to an FPGA-side FT245 core and moves payload
// to and from the environment over AXI-Stream.
//
// Handshake semantics: every AXIS beat transfers on a rising edge where
// tvalid & tready are both high; an FT245 read transfers on an edge with
// rdn=0, oen=0, rxfn=0, and an FT245 write on an edge with wrn=0, txen=0.
// All status flags (s_axis_tready, m_axis_tvalid, txen, rxfn) are registered.

// Small FIFO with a registered first-word-fall-through head and registered
// space/data flags computed from the next-state occupancy.
module ft245_emu_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             can_push,
  output logic             has_data
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_count = (aw+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [aw:0]      count, count_next;
  logic             do_push, do_pop;
  logic [width-1:0] head_next;

  // Next-state occupancy, pointers and head word; flush empties everything.
  always_comb begin
    do_push     = push & can_push & ~flush;
    do_pop      = pop & has_data & ~flush;
    wr_ptr_next = do_push ? wr_ptr + aw'(1) : wr_ptr;
    rd_ptr_next = do_pop ? rd_ptr + aw'(1) : rd_ptr;
    count_next  = count + (aw+1)'(do_push) - (aw+1)'(do_pop);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
    head_next = '0;
    if (count_next == '0) begin
      head_next = '0;
    end else if (count == '0 || (count == (aw+1)'(1) && do_pop)) begin
      // The word being pushed becomes the head straight away.
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer, occupancy, head and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
      can_push  <= 1'b0;
      has_data  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      head_data <= head_next;
      can_push  <= ~flush & (count_next != full_count);
      has_data  <= (count_next != '0);
    end
  end
endmodule

module ft245_sync_device_emu #(
  parameter int bus_width  = 1,
  parameter int fifo_depth = 16
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [8*bus_width-1:0] ft245_data_in,
  input  logic [bus_width-1:0]   ft245_ben_in,
  output logic [8*bus_width-1:0] ft245_data_out,
  output logic [bus_width-1:0]   ft245_ben_out,
  output logic                   ft245_data_oe,
  input  logic                   ft245_rdn,
  input  logic                   ft245_wrn,
  input  logic                   ft245_oen,
  input  logic                   ft245_siwun,
  input  logic                   ft245_rstn,
  output logic                   ft245_txen,
  output logic                   ft245_rxfn,
  input  logic [8*bus_width-1:0] s_axis_tdata,
  input  logic [bus_width-1:0]   s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [8*bus_width-1:0] m_axis_tdata,
  output logic [bus_width-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);
  localparam int dw   = 8 * bus_width;
  localparam int rx_w = dw + bus_width;
  localparam int tx_w = dw + bus_width + 1;

  logic            flush;
  logic [rx_w-1:0] rx_head;
  logic            rx_can_push, rx_has_data;
  logic [tx_w-1:0] tx_head;
  logic            tx_can_push, tx_has_data;

  assign flush = ~ft245_rstn;

  // Host-to-FPGA direction: s_axis in, FT245 read out.
  ft245_emu_fifo #(.width(rx_w), .depth(fifo_depth)) u_rx_fifo (
    .clk       (aclk),
    .rst       (arst),
    .flush     (flush),
    .push      (s_axis_tvalid),
    .push_data ({s_axis_tkeep, s_axis_tdata}),
    .pop       (~ft245_rdn & ~ft245_oen),
    .head_data (rx_head),
    .can_push  (rx_can_push),
    .has_data  (rx_has_data)
  );

  // FPGA-to-host direction: FT245 write in, m_axis out; tlast rides along.
  ft245_emu_fifo #(.width(tx_w), .depth(fifo_depth)) u_tx_fifo (
    .clk       (aclk),
    .rst       (arst),
    .flush     (flush),
    .push      (~ft245_wrn),
    .push_data ({~ft245_siwun, ft245_ben_in, ft245_data_in}),
    .pop       (m_axis_tready),
    .head_data (tx_head),
    .can_push  (tx_can_push),
    .has_data  (tx_has_data)
  );

  assign s_axis_tready  = rx_can_push;
  assign ft245_rxfn     = ~rx_has_data;
  assign ft245_data_out = rx_head[dw-1:0];
  assign ft245_ben_out  = rx_head[rx_w-1:dw];

  assign ft245_txen    = ~tx_can_push;
  assign m_axis_tvalid = tx_has_data;
  assign m_axis_tdata  = tx_head[dw-1:0];
  assign m_axis_tkeep  = tx_head[dw+bus_width-1:dw];
  assign m_axis_tlast  = tx_head[tx_w-1];

  // Bus drive enable follows the core's output-enable request one cycle late.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      ft245_data_oe <= 1'b0;
    end else begin
      ft245_data_oe <= ~ft245_oen;
    end
  end
endmodule

// File: tb/tb_ft245_sync_device_emu.sv
// Bench for ft245_sync_device_emu: directed scenarios plus a randomized run,
// all compared against a queue-based model of the two byte streams.
module tb_ft245_sync_device_emu;
  localparam int bw    = 1;
  localparam int dw    = 8 * bw;
  localparam int depth = 16;

  logic          tb_data_clk;
  logic          arst;
  logic [dw-1:0] ft245_data_in;
  logic [bw-1:0] ft245_ben_in;
  logic [dw-1:0] ft245_data_out;
  logic [bw-1:0] ft245_ben_out;
  logic          ft245_data_oe;
  logic          ft245_rdn, ft245_wrn, ft245_oen, ft245_siwun, ft245_rstn;
  logic          ft245_txen, ft245_rxfn;
  logic [dw-1:0] s_axis_tdata;
  logic [bw-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready;
  logic [dw-1:0] m_axis_tdata;
  logic [bw-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;

  int errors = 0;
  int checks = 0;

  // Reference model: plain byte-stream queues plus expected flag values.
  logic [dw+bw-1:0] rx_exp_q[$];
  logic [dw+bw:0]   tx_exp_q[$];
  bit e_tready, e_txen, e_rxfn, e_tvalid, e_oe;

  ft245_sync_device_emu #(.bus_width(bw), .fifo_depth(depth)) dut (
    .aclk           (tb_data_clk),
    .arst           (arst),
    .ft245_data_in  (ft245_data_in),
    .ft245_ben_in   (ft245_ben_in),
    .ft245_data_out (ft245_data_out),
    .ft245_ben_out  (ft245_ben_out),
    .ft245_data_oe  (ft245_data_oe),
    .ft245_rdn      (ft245_rdn),
    .ft245_wrn      (ft245_wrn),
    .ft245_oen      (ft245_oen),
    .ft245_siwun    (ft245_siwun),
    .ft245_rstn     (ft245_rstn),
    .ft245_txen     (ft245_txen),
    .ft245_rxfn     (ft245_rxfn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready)
  );

  // Clock generation.
  initial begin
    tb_data_clk = 1'b0;
    forever #5 tb_data_clk = ~tb_data_clk;
  end

  task automatic model_reset();
    rx_exp_q.delete();
    tx_exp_q.delete();
    e_tready = 1'b0;
    e_txen   = 1'b1;
    e_rxfn   = 1'b1;
    e_tvalid = 1'b0;
    e_oe     = 1'b0;
  endtask

  task automatic idle_inputs();
    ft245_data_in = '0; ft245_ben_in = '0;
    ft245_rdn = 1'b1; ft245_wrn = 1'b1; ft245_oen = 1'b1;
    ft245_siwun = 1'b1; ft245_rstn = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  // Advance one clock: decide transfers from current inputs and model flags,
  // then update the stream queues and the flags they imply.
  task automatic step();
    bit rx_push, rx_pop, tx_cap, tx_pop, rstn_s, oen_s;
    logic [dw+bw-1:0] rx_word;
    logic [dw+bw:0]   tx_word;
    rx_push = s_axis_tvalid && e_tready;
    rx_pop  = !ft245_rdn && !ft245_oen && !e_rxfn;
    tx_cap  = !ft245_wrn && !e_txen;
    tx_pop  = m_axis_tready && e_tvalid;
    rstn_s  = ft245_rstn;
    oen_s   = ft245_oen;
    rx_word = {s_axis_tkeep, s_axis_tdata};
    tx_word = {~ft245_siwun, ft245_ben_in, ft245_data_in};
    @(posedge tb_data_clk);
    #1;
    if (!rstn_s) begin
      rx_exp_q.delete();
      tx_exp_q.delete();
    end else begin
      if (rx_pop) void'(rx_exp_q.pop_front());
      if (rx_push) rx_exp_q.push_back(rx_word);
      if (tx_pop) void'(tx_exp_q.pop_front());
      if (tx_cap) tx_exp_q.push_back(tx_word);
    end
    e_tready = rstn_s && (rx_exp_q.size() < depth);
    e_rxfn   = (rx_exp_q.size() == 0);
    e_txen   = !rstn_s || (tx_exp_q.size() == depth);
    e_tvalid = (tx_exp_q.size() != 0);
    e_oe     = !oen_s;
  endtask

  task automatic test_reset();
    idle_inputs();
    arst = 1'b1;
    #3;
    if (ft245_txen !== 1'b1) begin errors++; $display("FAIL reset_txen: got %0b want 1", ft245_txen); end
    checks++;
    if (ft245_rxfn !== 1'b1) begin errors++; $display("FAIL reset_rxfn: got %0b want 1", ft245_rxfn); end
    checks++;
    if (ft245_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %0b want 0", ft245_data_oe); end
    checks++;
    if ({ft245_ben_out, ft245_data_out} !== '0) begin errors++; $display("FAIL reset_data_out: got %h want 0", {ft245_ben_out, ft245_data_out}); end
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b want 0", s_axis_tready); end
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== '0) begin
      errors++; $display("FAIL reset_m_axis: got %h want 0", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    end
    checks++;
    @(posedge tb_data_clk);
    #1;
    arst = 1'b0;
    model_reset();
    step();
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %0b want 1", s_axis_tready); end
    checks++;
    if (ft245_txen !== 1'b0) begin errors++; $display("FAIL release_txen: got %0b want 0", ft245_txen); end
    checks++;
    if (ft245_rxfn !== 1'b1) begin errors++; $display("FAIL release_rxfn: got %0b want 1", ft245_rxfn); end
    checks++;
  endtask

  task automatic test_rx_read();
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(8'h41 + i);
      s_axis_tkeep  = 1'b1;
      step();
      if (i == 0) begin
        if (ft245_rxfn !== 1'b0) begin errors++; $display("FAIL rx_first_rxfn: got %0b want 0", ft245_rxfn); end
        checks++;
      end
    end
    s_axis_tvalid = 1'b0;
    ft245_oen = 1'b0;
    step();
    if (ft245_data_oe !== 1'b1) begin errors++; $display("FAIL rx_oe: got %0b want 1", ft245_data_oe); end
    checks++;
    ft245_rdn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ft245_data_out !== 8'(8'h41 + i) || ft245_ben_out !== 1'b1) begin
        errors++; $display("FAIL rx_read_%0d: got %h/%b want %h/1", i, ft245_data_out, ft245_ben_out, 8'(8'h41 + i));
      end
      checks++;
      if (ft245_rxfn !== 1'b0) begin errors++; $display("FAIL rx_rxfn_%0d: got %0b want 0", i, ft245_rxfn); end
      checks++;
      step();
    end
    if (ft245_rxfn !== 1'b1) begin errors++; $display("FAIL rx_empty_rxfn: got %0b want 1", ft245_rxfn); end
    checks++;
    ft245_rdn = 1'b1;
    ft245_oen = 1'b1;
    step();
    if (ft245_data_oe !== 1'b0) begin errors++; $display("FAIL rx_oe_off: got %0b want 0", ft245_data_oe); end
    checks++;
  endtask

  task automatic test_tx_stream();
    m_axis_tready = 1'b1;
    ft245_siwun = 1'b1;
    ft245_ben_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ft245_wrn = 1'b0;
      ft245_data_in = 8'(8'h10 + i);
      step();
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(8'h10 + i) || m_axis_tkeep !== 1'b1 || m_axis_tlast !== 1'b0) begin
        errors++; $display("FAIL tx_stream_%0d: got v=%0b d=%h k=%b l=%0b want v=1 d=%h k=1 l=0",
                           i, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, 8'(8'h10 + i));
      end
      checks++;
      if (ft245_txen !== 1'b0) begin errors++; $display("FAIL tx_stream_txen_%0d: got %0b want 0", i, ft245_txen); end
      checks++;
    end
    ft245_wrn = 1'b1;
    step();
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tx_stream_drain: got %0b want 0", m_axis_tvalid); end
    checks++;
  endtask

  task automatic test_tx_overflow();
    logic [dw-1:0] wr [20];
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr[i] = dw'($urandom);
      ft245_wrn = 1'b0;
      ft245_data_in = wr[i];
      step();
      if (ft245_txen !== (i >= depth - 1)) begin
        errors++; $display("FAIL tx_full_txen_%0d: got %0b want %0b", i, ft245_txen, (i >= depth - 1));
      end
      checks++;
    end
    ft245_wrn = 1'b1;
    m_axis_tready = 1'b1;
    for (int k = 0; k < depth; k++) begin
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== wr[k]) begin
        errors++; $display("FAIL tx_full_out_%0d: got v=%0b d=%h want v=1 d=%h", k, m_axis_tvalid, m_axis_tdata, wr[k]);
      end
      checks++;
      step();
    end
    if (m_axis_tvalid !== 1'b0 || ft245_txen !== 1'b0) begin
      errors++; $display("FAIL tx_full_end: got v=%0b txen=%0b want v=0 txen=0", m_axis_tvalid, ft245_txen);
    end
    checks++;
  endtask

  task automatic test_tlast();
    logic [dw-1:0] d [3];
    bit            l [3];
    d[0] = 8'h55; d[1] = 8'hAA; d[2] = 8'h66;
    l[0] = 1'b0;  l[1] = 1'b1;  l[2] = 1'b0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ft245_wrn = 1'b0;
      ft245_data_in = d[i];
      ft245_siwun = ~l[i];
      step();
    end
    ft245_wrn = 1'b1;
    ft245_siwun = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d[i] || m_axis_tlast !== l[i]) begin
        errors++; $display("FAIL tlast_%0d: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                           i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, d[i], l[i]);
      end
      checks++;
      step();
    end
  endtask

  task automatic test_flush();
    m_axis_tready = 1'b0;
    for (int i = 0; i < depth; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = dw'($urandom);
      s_axis_tkeep = bw'($urandom);
      ft245_wrn = (i >= 2);
      ft245_data_in = dw'($urandom);
      step();
    end
    ft245_wrn = 1'b1;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL flush_full_tready: got %0b want 0", s_axis_tready); end
    checks++;
    ft245_rstn = 1'b0;
    step();
    if (ft245_rxfn !== 1'b1 || ft245_txen !== 1'b1 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL flush_held: got rxfn=%0b txen=%0b tready=%0b tvalid=%0b want 1 1 0 0",
                         ft245_rxfn, ft245_txen, s_axis_tready, m_axis_tvalid);
    end
    checks++;
    ft245_rstn = 1'b1;
    s_axis_tvalid = 1'b0;
    step();
    if (ft245_rxfn !== 1'b1 || ft245_txen !== 1'b0 || s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL flush_release: got rxfn=%0b txen=%0b tready=%0b tvalid=%0b want 1 0 1 0",
                         ft245_rxfn, ft245_txen, s_axis_tready, m_axis_tvalid);
    end
    checks++;
  endtask

  task automatic test_arst_mid_read();
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = dw'($urandom);
      s_axis_tkeep = 1'b1;
      step();
    end
    s_axis_tvalid = 1'b0;
    ft245_oen = 1'b0;
    ft245_rdn = 1'b0;
    step();
    #2;
    arst = 1'b1;
    #1;
    if (ft245_rxfn !== 1'b1 || ft245_data_oe !== 1'b0 || ft245_data_out !== '0 || s_axis_tready !== 1'b0 || ft245_txen !== 1'b1) begin
      errors++; $display("FAIL arst_immediate: got rxfn=%0b oe=%0b d=%h tready=%0b txen=%0b want 1 0 00 0 1",
                         ft245_rxfn, ft245_data_oe, ft245_data_out, s_axis_tready, ft245_txen);
    end
    checks++;
    @(posedge tb_data_clk);
    #1;
    arst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      if (ft245_rxfn !== 1'b1 || ft245_data_oe !== 1'b1) begin
        errors++; $display("FAIL arst_after_%0d: got rxfn=%0b oe=%0b want rxfn=1 oe=1", i, ft245_rxfn, ft245_data_oe);
      end
      checks++;
    end
    ft245_oen = 1'b1;
    ft245_rdn = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [dw+bw-1:0] rx_h;
    logic [dw+bw:0]   tx_h;
    for (int c = 0; c < 600; c++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = dw'($urandom);
      s_axis_tkeep  = bw'($urandom);
      ft245_oen     = ($urandom_range(0, 3) == 0);
      ft245_rdn     = ($urandom_range(0, 2) == 0);
      ft245_wrn     = ($urandom_range(0, 2) == 0);
      ft245_data_in = dw'($urandom);
      ft245_ben_in  = bw'($urandom);
      ft245_siwun   = ($urandom_range(0, 7) != 0);
      ft245_rstn    = ($urandom_range(0, 63) != 0);
      m_axis_tready = ($urandom_range(0, 2) != 0);
      step();
      if ({s_axis_tready, ft245_rxfn, ft245_txen, m_axis_tvalid, ft245_data_oe} !== {e_tready, e_rxfn, e_txen, e_tvalid, e_oe}) begin
        errors++; $display("FAIL rand_flags_%0d: got tready,rxfn,txen,tvalid,oe=%b want %b", c,
                           {s_axis_tready, ft245_rxfn, ft245_txen, m_axis_tvalid, ft245_data_oe},
                           {e_tready, e_rxfn, e_txen, e_tvalid, e_oe});
      end
      checks++;
      if (!e_rxfn) begin
        rx_h = rx_exp_q[0];
        if ({ft245_ben_out, ft245_data_out} !== rx_h) begin
          errors++; $display("FAIL rand_rx_head_%0d: got %h want %h", c, {ft245_ben_out, ft245_data_out}, rx_h);
        end
        checks++;
      end
      if (e_tvalid) begin
        tx_h = tx_exp_q[0];
        if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== tx_h) begin
          errors++; $display("FAIL rand_tx_head_%0d: got %h want %h", c, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, tx_h);
        end
        checks++;
      end
    end
    idle_inputs();
    step();
  endtask

  // Scenario sequence and final report.
  initial begin
    idle_inputs();
    arst = 1'b1;
    model_reset();
    test_reset();
    test_rx_read();
    test_tx_stream();
    test_tx_overflow();
    test_tlast();
    test_flush();
    test_arst_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ft245_sync_device_emu.md
Name: ft245_sync_device_emu

Overview:
- Synthesizable emulator of the FTDI-chip side of the FT245 synchronous FIFO bus, i.e. the opposite end from the FPGA-side FT245-to-AXIS core.
- It presents txen/rxfn/data/ben to that core and exchanges payload with the test environment over AXIS.
- Host-to-FPGA bytes enter on s_axis and are read by the core; FPGA-to-host bytes written by the core leave on m_axis.
- It is intended for loopback benches and on-chip self-test with no FTDI part fitted.

Parameters:
bus_width, 1, bus width in bytes (1, 2 or 4).
fifo_depth, 16, entries per direction; power of 2, ≥ 4.

Ports:
aclk  input  1  clock; also the FT245 dclk presented to the core.
arst  input  1  asynchronous active-high reset.
ft245_data_in  input  8*bus_width  bus data driven by the core during writes.
ft245_ben_in  input  bus_width  byte enables driven by the core during writes.
ft245_data_out  output  8*bus_width  bus data driven toward the core during reads.
ft245_ben_out  output  bus_width  byte enables driven toward the core during reads.
ft245_data_oe  output  1  emulator is driving data/ben.
ft245_rdn  input  1  read strobe, active low.
ft245_wrn  input  1  write strobe, active low.
ft245_oen  input  1  output enable request, active low.
ft245_siwun  input  1  send-immediate, active low.
ft245_rstn  input  1  chip reset from the core, active low.
ft245_txen  output  1  low = emulator can accept a write.
ft245_rxfn  output  1  low = read data available.
s_axis_tdata  input  8*bus_width  host-to-FPGA data.
s_axis_tkeep  input  bus_width  host-to-FPGA byte enables.
s_axis_tvalid  input  1  AXIS valid.
s_axis_tready  output  1  AXIS ready.
m_axis_tdata  output  8*bus_width  FPGA-to-host data.
m_axis_tkeep  output  bus_width  copied from ft245_ben_in.
m_axis_tlast  output  1  set on a word written with siwun low.
m_axis_tvalid  output  1  AXIS valid.
m_axis_tready  input  1  AXIS ready.

Behaviour:
- Reset (arst high, async): both FIFOs empty.
  - ft245_txen=1, ft245_rxfn=1, ft245_data_oe=0.
  - ft245_data_out=0, ft245_ben_out=0.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0.
  - First edge after release: s_axis_tready=1 and txen=0.
- ft245_rstn low: synchronous flush of both FIFOs each cycle it is held.
  - txen=1, rxfn=1, s_axis_tready=0 while held.
- RX FIFO (s_axis -> core):
  - s_axis push when tvalid & tready.
  - s_axis_tready is registered: 1 when next-state count < fifo_depth.
- Read side:
  - ft245_data_oe is registered ~oen, so data is driven one cycle after oen falls.
  - ft245_data_out/ben_out always show the RX FIFO head (registered, first-word-fall-through).
  - Pop on a rising edge with rdn=0, oen=0 and rxfn=0.
  - rxfn is registered from next-state count==0, so it rises the cycle after the final pop.
  - rdn low while rxfn=1 has no effect.
  - Push and pop in the same cycle: count unchanged; data order preserved.
- TX FIFO (core -> m_axis):
  - Capture {data_in, ben_in, ~siwun} on an edge with wrn=0 and txen=0.
  - txen is registered: 1 when next-state count == fifo_depth.
  - wrn low while txen=1: word discarded, no state change.
- m_axis:
  - Standard AXIS; tdata/tkeep/tlast are held stable while tvalid & ~tready.
  - Pop on tvalid & tready.
  - Simultaneous capture and pop: count unchanged.
- Latency:
  - Core write to m_axis_tvalid: 1 cycle when the TX FIFO was empty.
  - s_axis push to rxfn low: 1 cycle.
- Pointers wrap modulo fifo_depth; count width is log2(fifo_depth)+1.
- Data/ben are never modified; ben=0 words are still transferred.
- arst mid-transfer: all in-flight words are lost; outputs take reset values immediately.

Test Plan:
- Reset, then push 0x41..0x44 on s_axis.
  - rxfn falls 1 cycle after the first push.
  - Core holds oen low, then rdn low for 4 cycles and reads 0x41,0x42,0x43,0x44 in order.
  - rxfn=1 the cycle after the 4th pop.
- m_axis_tready=1; core writes 0x10..0x1F with wrn low.
  - m_axis outputs 0x10..0x1F with tkeep=1 and tlast=0.
  - txen stays 0 throughout.
- m_axis_tready=0; core writes 20 words (fifo_depth=16).
  - txen=1 after the 16th capture.
  - Words 17-20 are dropped.
  - Raising tready yields exactly the first 16 words.
- Write 0xAA with siwun low -> m_axis_tlast=1 on that word only.
- Fill the RX FIFO, pulse ft245_rstn low for 1 cycle.
  - Both FIFOs empty; rxfn=1; s_axis_tready returns to 1 the cycle after release.
- Assert arst mid-read with 5 words pending.
  - Outputs immediately take reset values.
  - After release, rxfn=1 and no stale data is delivered.
